// File: rtl/dll_tx_arbiter.sv
// Data-link-layer transmit arbiter: picks between replay, DLLP and TLP sources
// and feeds the PHY framer through a single registered output stage.
module dll_tx_arbiter #(
    parameter int unsigned PIPE_DATA_WIDTH = 256,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                       sclk,
    input  logic                       srst,
    input  logic                       link_up_i,
    input  logic                       rpl_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] rpl_data_i,
    input  logic                       rpl_last_i,
    output logic                       rpl_ready_o,
    input  logic                       dllp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i,
    output logic                       dllp_ready_o,
    input  logic                       tlp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i,
    input  logic                       tlp_last_i,
    output logic                       tlp_ready_o,
    output logic                       phy_valid_o,
    output logic [PIPE_DATA_WIDTH-1:0] phy_data_o,
    output logic                       phy_last_o,
    input  logic                       phy_ready_i,
    output logic [1:0]                 grant_o
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StRpl, StTlp} state_e;
    typedef enum logic [1:0] {GntNone = 2'd0, GntRpl = 2'd1, GntDllp = 2'd2, GntTlp = 2'd3} gnt_e;

    state_e                     state_q, state_d;
    gnt_e                       gnt;
    logic [CntW-1:0]            wait_cnt_q, wait_cnt_d;
    logic                       phy_valid_q, phy_valid_d;
    logic [PIPE_DATA_WIDTH-1:0] phy_data_q, phy_data_d;
    logic                       phy_last_q, phy_last_d;
    logic                       load_en;
    logic                       sel_valid;
    logic [PIPE_DATA_WIDTH-1:0] sel_data;
    logic                       sel_last;
    logic                       accept;

    assign load_en = !phy_valid_q || phy_ready_i;

    // Owner selection: fixed owner mid-packet, combinational priority in IDLE.
    always_comb begin
        gnt = GntNone;
        case (state_q)
            StIdle: begin
                if (link_up_i) begin
                    if (rpl_valid_i) begin
                        gnt = GntRpl;
                    end else if (tlp_valid_i && (!dllp_valid_i || wait_cnt_q == CntMax)) begin
                        // A starved TLP is promoted over DLLPs, never over replay.
                        gnt = GntTlp;
                    end else if (dllp_valid_i) begin
                        gnt = GntDllp;
                    end
                end
            end
            StRpl:   gnt = GntRpl;
            StTlp:   gnt = GntTlp;
            default: gnt = GntNone;
        endcase
        if (srst) begin
            gnt = GntNone;
        end
    end

    // Source mux for the granted owner; DLLPs are always single-beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        case (gnt)
            GntRpl: begin
                sel_valid = rpl_valid_i;
                sel_data  = rpl_data_i;
                sel_last  = rpl_last_i;
            end
            GntDllp: begin
                sel_valid = dllp_valid_i;
                sel_data  = dllp_data_i;
                sel_last  = 1'b1;
            end
            GntTlp: begin
                sel_valid = tlp_valid_i;
                sel_data  = tlp_data_i;
                sel_last  = tlp_last_i;
            end
            default: ;
        endcase
    end

    assign accept       = sel_valid && load_en;
    assign rpl_ready_o  = (gnt == GntRpl)  && load_en;
    assign dllp_ready_o = (gnt == GntDllp) && load_en;
    assign tlp_ready_o  = (gnt == GntTlp)  && load_en;
    assign grant_o      = gnt;
    assign phy_valid_o  = phy_valid_q;
    assign phy_data_o   = phy_data_q;
    assign phy_last_o   = phy_last_q;

    // Next-state for FSM, starvation counter and output register.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        phy_valid_d = phy_valid_q;
        phy_data_d  = phy_data_q;
        phy_last_d  = phy_last_q;

        case (state_q)
            StIdle: begin
                if (accept && !sel_last) begin
                    if (gnt == GntRpl) begin
                        state_d = StRpl;
                    end else if (gnt == GntTlp) begin
                        state_d = StTlp;
                    end
                end
            end
            StRpl, StTlp: begin
                if (accept && sel_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept && gnt == GntTlp && state_q == StIdle) begin
            wait_cnt_d = '0;
        end else if (accept && gnt == GntDllp && tlp_valid_i && wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end

        if (load_en) begin
            phy_valid_d = accept;
            if (accept) begin
                phy_data_d = sel_data;
                phy_last_d = sel_last;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            phy_valid_q <= 1'b0;
            phy_data_q  <= '0;
            phy_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            phy_valid_q <= phy_valid_d;
            phy_data_q  <= phy_data_d;
            phy_last_q  <= phy_last_d;
        end
    end

endmodule
